// File: rtl/pipe_io_bank.sv
// pipe_io_bank: memory-mapped I/O bank for the CPU MEM stage.
// It holds NUM_OUT 32-bit output registers and NUM_IN synchronised,
// debounced input channels. Each input channel has a sticky change flag
// (write-1-to-clear) and an enable bit that gates the interrupt line.
// Ports:
//   clock, resetn        : clock (rising edge), async active-low reset
//   addr, we, re, wdata  : MEM-stage bus (addr[1:0] ignored)
//   in_port              : raw inputs, channel k = [k*IN_WIDTH +: IN_WIDTH]
//   hit                  : combinational decode of addr to a mapped register
//   rdata, rvalid        : registered read data, one cycle after re & hit
//   out_port             : output registers, port k = [k*32 +: 32]
//   irq                  : OR over k of status[k] & irqen[k]
module pipe_io_bank #(
  parameter int unsigned NUM_OUT    = 3,
  parameter int unsigned NUM_IN     = 3,
  parameter int unsigned IN_WIDTH   = 4,
  parameter int unsigned DEB_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [31:0]                  addr,
  input  logic                         we,
  input  logic                         re,
  input  logic [31:0]                  wdata,
  input  logic [NUM_IN*IN_WIDTH-1:0]   in_port,
  output logic                         hit,
  output logic [31:0]                  rdata,
  output logic                         rvalid,
  output logic [NUM_OUT*32-1:0]        out_port,
  output logic                         irq
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [NUM_OUT-1:0][31:0]         out_q, out_d;
  logic [NUM_IN-1:0][IN_WIDTH-1:0]  sync1_q, sync1_d;
  logic [NUM_IN-1:0][IN_WIDTH-1:0]  sync2_q, sync2_d;
  logic [NUM_IN-1:0][IN_WIDTH-1:0]  deb_q, deb_d;
  logic [NUM_IN-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_IN-1:0]                status_q, status_d;
  logic [NUM_IN-1:0]                irqen_q, irqen_d;
  logic [31:0]                      rdata_q, rdata_d;
  logic                             rvalid_q, rvalid_d;
  logic                             irq_q, irq_d;

  logic                             base_ok_c;
  logic                             sel_out_c, sel_in_c, sel_stat_c, sel_irqen_c;
  logic [3:0]                       idx_c;
  logic [NUM_IN-1:0]                set_c;

  // Address decode: OUT at 0x00+4k, IN at 0x40+4k, STATUS 0x80, IRQEN 0x84
  always_comb begin
    base_ok_c   = (addr[31:8] == BASE_ADDR[31:8]);
    idx_c       = addr[5:2];
    sel_out_c   = base_ok_c && (addr[7:6] == 2'b00) && (32'(idx_c) < NUM_OUT);
    sel_in_c    = base_ok_c && (addr[7:6] == 2'b01) && (32'(idx_c) < NUM_IN);
    sel_stat_c  = base_ok_c && (addr[7:2] == 6'h20);
    sel_irqen_c = base_ok_c && (addr[7:2] == 6'h21);
    hit         = sel_out_c | sel_in_c | sel_stat_c | sel_irqen_c;
  end

  // Next-state: synchronisers, debouncers, register writes, read mux
  always_comb begin
    out_d    = out_q;
    sync1_d  = in_port;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    irqen_d  = irqen_q;
    rdata_d  = '0;
    rvalid_d = 1'b0;
    set_c    = '0;

    // Debounce: deb follows the synchronised value once it has differed
    // for DEB_CYCLES consecutive edges; any return to deb restarts the count.
    for (int k = 0; k < NUM_IN; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_W'(DEB_CYCLES - 1)) begin
        deb_d[k] = sync2_q[k];
        cnt_d[k] = '0;
        set_c[k] = 1'b1;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end

    if (we && sel_out_c) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (idx_c == 4'(k)) out_d[k] = wdata;
      end
    end

    // W1C first, then new change events, so a coincident set wins
    if (we && sel_stat_c) status_d = status_q & ~wdata[NUM_IN-1:0];
    status_d = status_d | set_c;

    if (we && sel_irqen_c) irqen_d = wdata[NUM_IN-1:0];

    // Built from next-state values so irq tracks status/irqen on the same edge
    irq_d = |(status_d & irqen_d);

    if (re && hit) begin
      rvalid_d = 1'b1;
      if (sel_out_c) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (idx_c == 4'(k)) rdata_d = out_q[k];
        end
      end
      if (sel_in_c) begin
        for (int k = 0; k < NUM_IN; k++) begin
          if (idx_c == 4'(k)) rdata_d = 32'(deb_q[k]);
        end
      end
      if (sel_stat_c)  rdata_d = 32'(status_q);
      if (sel_irqen_c) rdata_d = 32'(irqen_q);
    end
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      irqen_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      irqen_q  <= irqen_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign out_port = out_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pipe_io_bank.sv
// tb_pipe_io_bank: directed self-checking bench for pipe_io_bank with
// default parameters (3 outputs, 3 x 4-bit inputs, DEB_CYCLES=4, base 0xFF00).
module tb_pipe_io_bank;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [11:0] in_port;
  logic        hit;
  logic [31:0] rdata;
  logic        rvalid;
  logic [95:0] out_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_d;
  logic        rd_v;

  pipe_io_bank dut (
    .clock    (clock),
    .resetn   (resetn),
    .addr     (addr),
    .we       (we),
    .re       (re),
    .wdata    (wdata),
    .in_port  (in_port),
    .hit      (hit),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .out_port (out_port),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One write cycle, driven after a falling edge, captured at the next rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clock);
    we = 1'b0;
  endtask

  // One read cycle; result sampled at the falling edge after the capture edge
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clock);
    addr = a;
    re   = 1'b1;
    @(negedge clock);
    re = 1'b0;
    d  = rdata;
    v  = rvalid;
  endtask

  initial begin
    resetn  = 1'b0;
    addr    = 32'h0;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = 32'h0;
    in_port = 12'h0;
    repeat (3) @(negedge clock);
    check("rst_out", out_port[31:0], 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    resetn = 1'b1;

    // Output register write / read, and read+write in the same cycle
    wr(32'hFF04, 32'hDEADBEEF);
    check("out1_port", out_port[63:32], 32'hDEADBEEF);
    rd(32'hFF04, rd_d, rd_v);
    check("out1_rvalid", 32'(rd_v), 32'h1);
    check("out1_rdata", rd_d, 32'hDEADBEEF);
    @(negedge clock);
    check("rvalid_drop", 32'(rvalid), 32'h0);
    addr  = 32'hFF04;
    wdata = 32'h1234;
    we    = 1'b1;
    re    = 1'b1;
    #1 check("hit_ff04", 32'(hit), 32'h1);
    @(negedge clock);
    we = 1'b0;
    re = 1'b0;
    check("rw_old_rdata", rdata, 32'hDEADBEEF);
    check("rw_new_port", out_port[63:32], 32'h1234);

    // Debounce ch1: deb updates at edge 6, so a read captured at edge 7
    // is the first to return 0xA.
    @(negedge clock);
    in_port[7:4] = 4'hA;
    addr = 32'hFF44;
    re   = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      check($sformatf("in1_edge%0d", n), rdata, (n >= 7) ? 32'hA : 32'h0);
    end
    re = 1'b0;
    rd(32'hFF80, rd_d, rd_v);
    check("status_ch1", rd_d, 32'h2);

    // Two-cycle pulse on ch0 never reaches the debounce threshold
    @(negedge clock);
    in_port[3:0] = 4'h1;
    @(negedge clock);
    @(negedge clock);
    in_port[3:0] = 4'h0;
    repeat (8) @(negedge clock);
    rd(32'hFF40, rd_d, rd_v);
    check("pulse_in0", rd_d, 32'h0);
    rd(32'hFF80, rd_d, rd_v);
    check("pulse_status", rd_d, 32'h2);

    // Status / IRQEN / irq
    @(negedge clock);
    in_port[3:0] = 4'h1;
    repeat (8) @(negedge clock);
    rd(32'hFF80, rd_d, rd_v);
    check("status_011", rd_d, 32'h3);
    wr(32'hFF84, 32'hFFFF_FFFA);
    check("irq_on", 32'(irq), 32'h1);
    rd(32'hFF84, rd_d, rd_v);
    check("irqen_rd", rd_d, 32'h2);
    wr(32'hFF80, 32'h2);
    check("irq_off", 32'(irq), 32'h0);
    rd(32'hFF80, rd_d, rd_v);
    check("status_w1c", rd_d, 32'h1);

    // ch0 returns to 0; its deb update (edge 6) coincides with W1C of bit0
    @(negedge clock);
    in_port[3:0] = 4'h0;
    repeat (5) @(negedge clock);
    addr  = 32'hFF80;
    wdata = 32'h1;
    we    = 1'b1;
    @(negedge clock);
    we = 1'b0;
    rd(32'hFF80, rd_d, rd_v);
    check("set_wins", rd_d, 32'h1);
    rd(32'hFF40, rd_d, rd_v);
    check("in0_back0", rd_d, 32'h0);
    wr(32'hFF80, 32'h1);
    rd(32'hFF80, rd_d, rd_v);
    check("status_clr", rd_d, 32'h0);

    // Decode of unmapped offsets
    @(negedge clock);
    addr  = 32'hFF0C;
    wdata = 32'h55;
    we    = 1'b1;
    #1 check("hit_ff0c", 32'(hit), 32'h0);
    @(negedge clock);
    addr = 32'hFF88;
    #1 check("hit_ff88", 32'(hit), 32'h0);
    @(negedge clock);
    we = 1'b0;
    check("dec_out2", out_port[95:64], 32'h0);
    check("dec_out1", out_port[63:32], 32'h1234);
    check("dec_out0", out_port[31:0], 32'h0);
    rd(32'hFF84, rd_d, rd_v);
    check("dec_irqen", rd_d, 32'h2);
    rd(32'hFF0C, rd_d, rd_v);
    check("dec_rvalid0c", 32'(rd_v), 32'h0);
    check("dec_rdata0c", rd_d, 32'h0);
    rd(32'hFF88, rd_d, rd_v);
    check("dec_rvalid88", 32'(rd_v), 32'h0);
    addr = 32'hFE00;
    #1 check("hit_fe00", 32'(hit), 32'h0);

    // Reset in the middle of a read with OUT0=5 and irq asserted
    wr(32'hFF00, 32'h5);
    check("out0_5", out_port[31:0], 32'h5);
    wr(32'hFF84, 32'h2);
    @(negedge clock);
    in_port[7:4] = 4'h0;
    repeat (8) @(negedge clock);
    check("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge clock);
    addr = 32'hFF00;
    re   = 1'b1;
    @(negedge clock);
    re = 1'b0;
    check("pre_rst_rvalid", 32'(rvalid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_out0", out_port[31:0], 32'h0);
    check("mid_rst_out1", out_port[63:32], 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_rvalid", 32'(rvalid), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    rd(32'hFF00, rd_d, rd_v);
    check("post_rst_rvalid", 32'(rd_v), 32'h1);
    check("post_rst_rdata", rd_d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_io_bank.md
Name: pipe_io_bank

Overview:
- Parametrised memory-mapped I/O bank for the pipelined CPU's MEM stage. It replaces fixed three-port in/out wiring with NUM_OUT output registers and NUM_IN debounced input channels.
- Adds per-input change-detect status (write-1-to-clear) and a maskable interrupt line.
- The MEM stage drives addr/we/re from malu/mwmem. It muxes rdata onto mmo when hit is set.

Parameters:
- NUM_OUT, 3, number of 32-bit output registers (1..16)
- NUM_IN, 3, number of input channels (1..16)
- IN_WIDTH, 4, bits per input channel (1..32)
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced input updates (>=1)
- BASE_ADDR, 32'h0000_FF00, base byte address of the 256-byte window (256-aligned)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- addr  in  32  byte address; addr[1:0] ignored
- we  in  1  write strobe, sampled at rising edge
- re  in  1  read strobe, sampled at rising edge
- wdata  in  32  write data
- in_port  in  NUM_IN*IN_WIDTH  raw asynchronous inputs; channel k = bits [k*IN_WIDTH +: IN_WIDTH]
- hit  out  1  combinational: addr decodes to an existing register
- rdata  out  32  registered read data
- rvalid  out  1  rdata valid for this cycle
- out_port  out  NUM_OUT*32  output registers; port k = bits [k*32 +: 32]
- irq  out  1  OR over k of status[k] & irqen[k]

Behaviour:
- Reset (asynchronous, resetn=0) clears the following to 0: out regs, sync flops, debounced values, debounce counters, status, irqen, rdata, rvalid. irq is therefore 0.
- Register map (offset = addr - BASE_ADDR):
  - 0x00+4k: OUT k, R/W, k<NUM_OUT.
  - 0x40+4k: IN k, RO; returns the debounced value, zero-extended.
  - 0x80: STATUS, bits[NUM_IN-1:0]; sticky change flags; writing 1 to a bit clears it.
  - 0x84: IRQEN, R/W, bits[NUM_IN-1:0]; upper bits read 0.
- hit=1 only when addr[31:8]==BASE_ADDR[31:8] and the offset names an existing register. Unmapped offsets give hit=0; writes to them are ignored and reads return nothing (rvalid=0).
- Writes: when we & hit, the target register updates at the rising edge. Writes to IN are ignored.
- Reads: when re & hit at edge N, rdata = the register value before edge N and rvalid=1 during cycle N+1. Latency is 1 cycle.
  - Otherwise, rvalid=0 and rdata=0.
  - A same-cycle read and write to the same register returns the old value.
- Input path per channel: two-flop synchroniser produces s, then a debouncer with deb and cnt.
  - s==deb: cnt<=0.
  - s!=deb and cnt<DEB_CYCLES-1: cnt<=cnt+1.
  - s!=deb and cnt==DEB_CYCLES-1: deb<=s, cnt<=0, status[k] set.
  - A pin stable from before edge 1 updates deb at edge 2+DEB_CYCLES.
  - A bounce back to deb before that restarts the count.
- Status set and W1C clear of the same bit in the same cycle: the set wins and the bit stays 1.
- irq is derived from registers only. It is glitch-free and updates in the cycle after the status/irqen edge.
- A multi-bit channel whose bits change on different cycles updates deb once, with the value stable for DEB_CYCLES cycles.

Test Plan:
- Reset then read: assert resetn=0 mid-operation with OUT0=5 written. Required: out_port=0, irq=0, rvalid=0 immediately. After release, reading 0xFF00 gives rdata=0 with rvalid one cycle after re.
- Write/read out: write 0xDEADBEEF to 0xFF04. Required: out_port[63:32]=0xDEADBEEF after the edge. A read of 0xFF04 returns 0xDEADBEEF with rvalid=1 exactly 1 cycle later. A same-cycle read+write of 0x1234 to 0xFF04 returns 0xDEADBEEF.
- Debounce: DEB_CYCLES=4; in_port ch1 goes 0->4'hA before edge 1 and holds. Required: IN1 (0xFF44) reads 0 through edge 5 and 0xA from edge 6; STATUS bit1=1. A 2-cycle pulse on ch0 never changes IN0 or status.
- W1C/irq: status=3'b011, IRQEN=3'b010. Required: irq=1. Writing 0x2 to 0xFF80 gives STATUS=3'b001 and irq=0. If W1C of bit0 lands on the same edge as a new ch0 change, bit0 stays 1.
- Decode: write 0x55 to 0xFF0C (NUM_OUT=3) and to 0xFF88, then read both. Required: hit=0, no register changes, rvalid=0. Reading 0xFE00 also gives hit=0.
